// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment scanner.
package display_pkg;
  localparam int NUM_DIGITS = 4;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BLANK_CODE = 4'b1111;
endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot counter: pulses slot_tick once every PRESCALE clock cycles.
module scan_prescaler #(
  parameter int PRESCALE = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic slot_tick
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign slot_tick = (r_cnt == LAST);
endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit display scanner with a pending/active double buffer so that a
// newly loaded value only ever appears starting at a frame boundary.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        lz_en,
  output logic [1:0]  refrescamiento,
  output logic [3:0]  anode,
  output logic [3:0]  DIGITO,
  output logic        frame_tick
);

  logic        w_slot_tick;
  logic        w_boundary;
  logic        w_xfer;
  logic [1:0]  w_ref_nxt;
  logic [15:0] w_active_nxt;
  bcd_t        w_digit_nxt;

  logic        r_started;
  logic [1:0]  r_ref;
  logic [3:0]  r_anode;
  bcd_t        r_digit;
  logic        r_frame_tick;
  logic [15:0] r_pending;
  logic [15:0] r_active;
  logic        r_pend_full;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .slot_tick (w_slot_tick)
  );

  // Non-BCD digits are blanked; with lz on, a position is blanked when it and
  // every position to its left are zero (the rightmost digit always shows).
  function automatic bcd_t digit_code(input logic [15:0] val, input logic [1:0] pos,
                                      input logic lz);
    int   p;
    bcd_t d;
    logic zero_above;
    p          = int'(pos);
    d          = val[p*4 +: 4];
    zero_above = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= p && val[k*4 +: 4] != 4'd0) zero_above = 1'b0;
    end
    if (d > 4'd9) return BLANK_CODE;
    if (lz && p != 0 && zero_above) return BLANK_CODE;
    return d;
  endfunction

  // The first slot after reset lights position 0 without advancing the index.
  assign w_boundary   = w_slot_tick && r_started && (r_ref == 2'd3);
  assign load_ready   = !r_pend_full;
  assign w_xfer       = load_valid && load_ready;
  assign w_ref_nxt    = r_started ? r_ref + 2'd1 : 2'd0;
  assign w_active_nxt = (w_boundary && r_pend_full) ? r_pending : r_active;
  assign w_digit_nxt  = digit_code(w_active_nxt, w_ref_nxt, lz_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_started    <= 1'b0;
      r_ref        <= 2'd0;
      r_anode      <= 4'b1111;
      r_digit      <= BLANK_CODE;
      r_frame_tick <= 1'b0;
      r_pending    <= 16'h0000;
      r_active     <= 16'h0000;
      r_pend_full  <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      if (w_slot_tick) begin
        r_started <= 1'b1;
        r_ref     <= w_ref_nxt;
        r_anode   <= ~(4'b0001 << w_ref_nxt);
        r_digit   <= w_digit_nxt;
      end
      // load_ready is low whenever the swap fires, so the two never collide.
      if (w_boundary && r_pend_full) begin
        r_active    <= r_pending;
        r_pend_full <= 1'b0;
      end else if (w_xfer) begin
        r_pending   <= value_in;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign refrescamiento = r_ref;
  assign anode          = r_anode;
  assign DIGITO         = r_digit;
  assign frame_tick     = r_frame_tick;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=4 (one digit slot = 4 cycles).
module tb_display_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic        load_valid;
  logic        load_ready;
  logic        lz_en;
  logic [1:0]  refrescamiento;
  logic [3:0]  anode;
  logic [3:0]  DIGITO;
  logic        frame_tick;

  int n_chk  = 0;
  int n_pass = 0;

  display_scan_ctrl #(.PRESCALE(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .value_in       (value_in),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .lz_en          (lz_en),
    .refrescamiento (refrescamiento),
    .anode          (anode),
    .DIGITO         (DIGITO),
    .frame_tick     (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_pos(input string tag, input logic [3:0] an, input logic [3:0] dg);
    chk({tag, "_anode"}, {12'h0, anode}, {12'h0, an});
    chk({tag, "_digit"}, {12'h0, DIGITO}, {12'h0, dg});
  endtask

  task automatic to_boundary();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (frame_tick) seen = 1'b1;
    end
    chk("frame_tick_seen", {15'h0, frame_tick}, 16'h0001);
  endtask

  task automatic load(input logic [15:0] v);
    value_in   = v;
    load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; value_in = 16'h0; load_valid = 1'b0; lz_en = 1'b0;
    step(2);
    chk("rst_anode", {12'h0, anode}, 16'h000F);
    chk("rst_digit", {12'h0, DIGITO}, 16'h000F);
    chk("rst_ref", {14'h0, refrescamiento}, 16'h0000);
    chk("rst_ftick", {15'h0, frame_tick}, 16'h0000);
    chk("rst_ready", {15'h0, load_ready}, 16'h0001);
    reset = 1'b0;

    // Idle scan after reset
    step(3);  chk("pre_first_slot_anode", {12'h0, anode}, 16'h000F);
    step(1);  chk_pos("idle_p0", 4'hE, 4'h0); chk("idle_ref0", {14'h0, refrescamiento}, 16'h0000);
    step(4);  chk_pos("idle_p1", 4'hD, 4'h0); chk("idle_ref1", {14'h0, refrescamiento}, 16'h0001);
    step(4);  chk_pos("idle_p2", 4'hB, 4'h0);
    step(4);  chk_pos("idle_p3", 4'h7, 4'h0); chk("idle_ref3", {14'h0, refrescamiento}, 16'h0003);
    chk("ftick_before_wrap", {15'h0, frame_tick}, 16'h0000);
    step(4);  chk("ftick_at_wrap", {15'h0, frame_tick}, 16'h0001); chk_pos("wrap_p0", 4'hE, 4'h0);
    step(1);  chk("ftick_one_cycle", {15'h0, frame_tick}, 16'h0000);

    // Mid-frame load of 1234
    step(4);
    load(16'h1234);
    chk("ready_drop", {15'h0, load_ready}, 16'h0000);
    chk_pos("midframe_unchanged_p1", 4'hD, 4'h0);
    step(6);  chk_pos("midframe_unchanged_p3", 4'h7, 4'h0);
    to_boundary();
    chk_pos("v1234_p0", 4'hE, 4'h4);
    chk("ready_back", {15'h0, load_ready}, 16'h0001);
    step(4);  chk_pos("v1234_p1", 4'hD, 4'h3);
    step(4);  chk_pos("v1234_p2", 4'hB, 4'h2);
    step(4);  chk_pos("v1234_p3", 4'h7, 4'h1);

    // 0070 with leading-zero blanking, then without
    lz_en = 1'b1;
    load(16'h0070);
    to_boundary();
    chk_pos("v0070lz_p0", 4'hE, 4'h0);
    step(4);  chk_pos("v0070lz_p1", 4'hD, 4'h7);
    step(4);  chk_pos("v0070lz_p2", 4'hB, 4'hF);
    step(4);  chk_pos("v0070lz_p3", 4'h7, 4'hF);
    lz_en = 1'b0;
    to_boundary();
    chk_pos("v0070_p0", 4'hE, 4'h0);
    step(4);  chk_pos("v0070_p1", 4'hD, 4'h7);
    step(4);  chk_pos("v0070_p2", 4'hB, 4'h0);
    step(4);  chk_pos("v0070_p3", 4'h7, 4'h0);

    // 00A5: non-BCD blanked; lz_en dropped mid-frame takes effect immediately
    lz_en = 1'b1;
    load(16'h00A5);
    to_boundary();
    chk_pos("v00A5_p0", 4'hE, 4'h5);
    step(4);  chk_pos("v00A5_p1", 4'hD, 4'hF);
    lz_en = 1'b0;
    step(4);  chk_pos("v00A5_p2_nolz", 4'hB, 4'h0);
    step(4);  chk_pos("v00A5_p3_nolz", 4'h7, 4'h0);

    // Back-to-back loads with valid held
    value_in = 16'h1111; load_valid = 1'b1;
    step(1);
    value_in = 16'h2222;
    chk("b2b_ready_low", {15'h0, load_ready}, 16'h0000);
    to_boundary();
    chk_pos("b2b_1111_p0", 4'hE, 4'h1);
    chk("b2b_ready_after_swap", {15'h0, load_ready}, 16'h0001);
    step(1);
    load_valid = 1'b0;
    chk("b2b_second_accepted", {15'h0, load_ready}, 16'h0000);
    step(3);  chk_pos("b2b_1111_p1", 4'hD, 4'h1);
    step(4);  chk_pos("b2b_1111_p2", 4'hB, 4'h1);
    step(4);  chk_pos("b2b_1111_p3", 4'h7, 4'h1);
    to_boundary();
    chk_pos("b2b_2222_p0", 4'hE, 4'h2);
    step(4);  chk_pos("b2b_2222_p1", 4'hD, 4'h2);

    // Reset with a pending value during position 2
    load(16'h9999);
    step(3);
    chk_pos("pre_rst_p2", 4'hB, 4'h2);
    chk("pre_rst_pending_full", {15'h0, load_ready}, 16'h0000);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mrst_anode", {12'h0, anode}, 16'h000F);
    chk("mrst_digit", {12'h0, DIGITO}, 16'h000F);
    chk("mrst_ref", {14'h0, refrescamiento}, 16'h0000);
    chk("mrst_ftick", {15'h0, frame_tick}, 16'h0000);
    chk("mrst_ready", {15'h0, load_ready}, 16'h0001);
    step(3);  chk("mrst_anode_hold", {12'h0, anode}, 16'h000F);
    step(1);  chk_pos("mrst_p0", 4'hE, 4'h0);
    to_boundary();
    chk_pos("mrst_pending_discarded", 4'hE, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
